spi_shift_engine: RTL and testbench

//  Parametrised SPI master shift engine; successor to the unidirectional shift register.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sck_gen.sv | 56 +++++
 rtl/spi_shift_engine.sv | 145 ++++++++++++++
 tb/tb_spi_shift_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
// Mode index is {cpol, cpha}.
package spi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider and edge counter: emits one strobe per SCK edge,
// classified as leading/trailing, plus the final edge of the frame.
module spi_sck_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_cpol,
  input  logic i_cpol_q,
  output logic o_sclk,
  output logic o_lead_stb,
  output logic o_trail_stb,
  output logic o_last_edge
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

  logic [DW-1:0] r_div;
  logic [EW-1:0] r_edge;
  logic          r_sclk;
  logic          w_tc;
  logic [EW-1:0] w_edge_nxt;

  assign w_tc       = i_run && (r_div == DIV_MAX);
  assign w_edge_nxt = r_edge + 1'b1;

  // Odd edge numbers are leading edges, even ones trailing.
  assign o_lead_stb  = w_tc && w_edge_nxt[0];
  assign o_trail_stb = w_tc && !w_edge_nxt[0];
  assign o_last_edge = w_tc && (r_edge == EDGE_LAST);
  assign o_sclk      = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= i_cpol;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) begin
        r_edge <= o_last_edge ? '0 : w_edge_nxt;
        r_sclk <= o_last_edge ? i_cpol_q : !r_sclk;
      end
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: handshake FSM, tx/rx shift registers,
// all four CPOL/CPHA modes and selectable bit order.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsb_first,
  input  logic                  i_miso,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_sclk,
  output logic                  o_mosi
);

  localparam int W = DATA_WIDTH;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_tx;
  logic [W-1:0]   r_rx;
  logic [W-1:0]   r_rx_data;
  logic [W-1:0]   w_rx_nxt;
  logic           r_mosi;
  logic           r_done;
  logic           r_cpol;
  logic           r_cpha;
  logic           r_lsb;
  logic           w_accept;
  logic           w_lead;
  logic           w_trail;
  logic           w_last;
  logic           w_samp;
  logic           w_drive;

  function automatic logic f_head(
    input logic [W-1:0] d,
    input logic         lsb
  );
    return lsb ? d[0] : d[W-1];
  endfunction

  function automatic logic [W-1:0] f_shift(
    input logic [W-1:0] d,
    input logic         lsb
  );
    return lsb ? {1'b0, d[W-1:1]} : {d[W-2:0], 1'b0};
  endfunction

  spi_sck_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_sck (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (r_state == ST_XFER),
    .i_cpol     (i_cpol),
    .i_cpol_q   (r_cpol),
    .o_sclk     (o_sclk),
    .o_lead_stb (w_lead),
    .o_trail_stb(w_trail),
    .o_last_edge(w_last)
  );

  assign o_ready   = (r_state == ST_IDLE);
  assign o_busy    = (r_state == ST_XFER);
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;
  assign o_mosi    = r_mosi;
  assign w_accept  = i_start && o_ready;

  // The final trailing edge in CPHA=0 has no next bit to drive.
  assign w_samp  = r_cpha ? w_trail : w_lead;
  assign w_drive = r_cpha ? w_lead : (w_trail && !w_last);

  always_comb begin
    w_rx_nxt = r_rx;
    if (w_samp) begin
      w_rx_nxt = r_lsb ? {i_miso, r_rx[W-1:1]}
                       : {r_rx[W-2:0], i_miso};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_XFER;
      ST_XFER: if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '1;
      r_mosi    <= 1'b1;
      r_done    <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cpol <= i_cpol;
        r_cpha <= i_cpha;
        r_lsb  <= i_lsb_first;
        r_rx   <= '0;
        if (i_cpha) begin
          r_tx <= i_tx_data;
        end else begin
          r_mosi <= f_head(i_tx_data, i_lsb_first);
          r_tx   <= f_shift(i_tx_data, i_lsb_first);
        end
      end else if (r_state == ST_XFER) begin
        r_rx <= w_rx_nxt;
        if (w_drive) begin
          r_mosi <= f_head(r_tx, r_lsb);
          r_tx   <= f_shift(r_tx, r_lsb);
        end
        if (w_last) begin
          r_mosi    <= 1'b1;
          r_done    <= 1'b1;
          r_rx_data <= w_rx_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with CLK_DIV 2, 1 and 3
// instances sharing stimulus; sel picks the instance under test.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb = 1'b0;
  logic       miso_drv = 1'b1;
  logic       lb = 1'b1;
  logic [7:0] tx = '0;
  logic [7:0] slave = '0;
  logic [1:0] sel = 2'd0;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  logic [2:0] stk, rdy, bsy, dn, sck, mo, mi;
  logic [7:0] rx [3];

  logic       w_ready, w_busy, w_done, w_sclk, w_mosi;
  logic [7:0] w_rx;

  always #5 clk = ~clk;

  assign stk = {start && sel == 2'd2,
                start && sel == 2'd1,
                start && sel == 2'd0};
  assign mi = lb ? mo : {3{miso_drv}};

  assign w_ready = rdy[sel];
  assign w_busy  = bsy[sel];
  assign w_done  = dn[sel];
  assign w_sclk  = sck[sel];
  assign w_mosi  = mo[sel];
  assign w_rx    = rx[sel];

  spi_shift_engine #(.DATA_WIDTH(8), .CLK_DIV(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_start(stk[0]), .i_tx_data(tx),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb), .i_miso(mi[0]),
    .o_ready(rdy[0]), .o_busy(bsy[0]), .o_done(dn[0]),
    .o_rx_data(rx[0]), .o_sclk(sck[0]), .o_mosi(mo[0])
  );

  spi_shift_engine #(.DATA_WIDTH(8), .CLK_DIV(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_start(stk[1]), .i_tx_data(tx),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb), .i_miso(mi[1]),
    .o_ready(rdy[1]), .o_busy(bsy[1]), .o_done(dn[1]),
    .o_rx_data(rx[1]), .o_sclk(sck[1]), .o_mosi(mo[1])
  );

  spi_shift_engine #(.DATA_WIDTH(8), .CLK_DIV(3)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_start(stk[2]), .i_tx_data(tx),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb), .i_miso(mi[2]),
    .o_ready(rdy[2]), .o_busy(bsy[2]), .o_done(dn[2]),
    .o_rx_data(rx[2]), .o_sclk(sck[2]), .o_mosi(mo[2])
  );

  always @(negedge clk) if (w_done) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sbit(input int idx);
    return lsb ? slave[idx] : slave[7-idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns in the o_done cycle.
  task automatic frame_obs(input bit restart, input bit abort,
                           input bit toggle, output int len,
                           output int rises, output int ne,
                           output int bad, output logic [7:0] seq,
                           output logic tmo);
    logic ps, pm, samp;
    int   si, idx;
    len = 0; rises = 0; ne = 0; bad = 0;
    seq = '0; si = 0; tmo = 1'b1;
    ps = w_sclk; pm = w_mosi;
    miso_drv = sbit(0);
    while (len < 400) begin
      tick();
      len++;
      if (restart && len == 4) start = 1'b1;
      if (restart && len == 5) start = 1'b0;
      if (toggle) cpol = ~cpol;
      if (w_sclk !== ps) begin
        ne++;
        if (w_sclk) rises++;
        samp = cpha ? (ne % 2 == 0) : (ne % 2 == 1);
        if (samp && si < 8) begin
          seq[si] = pm;
          si++;
        end
        if (samp && w_mosi !== pm && ne != 16) bad++;
        idx = cpha ? (ne - 1) / 2 : ne / 2;
        if (idx < 8) miso_drv = sbit(idx);
        if (abort && ne == 8) begin
          rst = 1'b1;
          tmo = 1'b0;
          return;
        end
      end else if (w_mosi !== pm) begin
        bad++;
      end
      ps = w_sclk;
      pm = w_mosi;
      if (w_done) begin
        if (restart) start = 1'b1;
        tmo = 1'b0;
        return;
      end
    end
  endtask

  int         len, rises, ne, bad, nd0;
  logic [7:0] seq;
  logic       tmo;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst busy", w_busy, 0);
    chk("rst done", w_done, 0);
    chk("rst ready", w_ready, 1);
    chk("rst sclk", w_sclk, 0);
    chk("rst mosi", w_mosi, 1);
    chk("rst rx", w_rx, 8'hFF);

    // Mode0 MSB-first loopback at DIV=2.
    sel = 2'd0; cpol = 0; cpha = 0; lsb = 0; lb = 1; tx = 8'hA5;
    kick();
    chk("t1 busy", w_busy, 1);
    chk("t1 ready", w_ready, 0);
    frame_obs(0, 0, 0, len, rises, ne, bad, seq, tmo);
    chk("t1 tmo", tmo, 0);
    chk("t1 rx", w_rx, 8'hA5);
    chk("t1 len", len, 32);
    chk("t1 rises", rises, 8);
    chk("t1 edges", ne, 16);
    chk("t1 seq", seq, 8'hA5);
    chk("t1 bad", bad, 0);
    tick();
    chk("t1 done1cy", w_done, 0);

    // Reset at edge 8 aborts the frame.
    tx = 8'h3B;
    nd0 = n_done;
    kick();
    frame_obs(0, 1, 0, len, rises, ne, bad, seq, tmo);
    chk("t5 tmo", tmo, 0);
    tick();
    rst = 1'b0;
    chk("t5 busy", w_busy, 0);
    chk("t5 sclk", w_sclk, 0);
    chk("t5 mosi", w_mosi, 1);
    chk("t5 rx", w_rx, 8'hFF);
    repeat (40) tick();
    chk("t5 nodone", n_done - nd0, 0);

    // Mode3 LSB-first against a slave returning 5A.
    cpol = 1; cpha = 1; lsb = 1; lb = 0; tx = 8'h3C; slave = 8'h5A;
    kick();
    chk("t2 idle hi", w_sclk, 1);
    frame_obs(0, 0, 0, len, rises, ne, bad, seq, tmo);
    chk("t2 tmo", tmo, 0);
    chk("t2 seq", seq, 8'h3C);
    chk("t2 rx", w_rx, 8'h5A);
    chk("t2 end hi", w_sclk, 1);
    chk("t2 len", len, 32);
    chk("t2 bad", bad, 0);

    // All modes at DIV=1 and DIV=3, loopback.
    lb = 1;
    for (int s = 1; s < 3; s++) begin
      for (int m = 0; m < 4; m++) begin
        sel  = 2'(s);
        cpol = m[1];
        cpha = m[0];
        lsb  = (s == 2);
        tx   = 8'($urandom);
        kick();
        frame_obs(0, 0, 0, len, rises, ne, bad, seq, tmo);
        chk($sformatf("t3 tmo s%0d m%0d", s, m), tmo, 0);
        chk($sformatf("t3 rx s%0d m%0d", s, m), w_rx, tx);
        chk($sformatf("t3 len s%0d m%0d", s, m), len,
            (s == 1) ? 16 : 48);
        chk($sformatf("t3 bad s%0d m%0d", s, m), bad, 0);
        chk($sformatf("t3 end s%0d m%0d", s, m), w_sclk, cpol);
      end
    end

    // Start mid-frame ignored; start in done cycle accepted.
    sel = 2'd0; cpol = 0; cpha = 0; lsb = 0; tx = 8'h96;
    nd0 = n_done;
    kick();
    frame_obs(1, 0, 0, len, rises, ne, bad, seq, tmo);
    chk("t4 tmo a", tmo, 0);
    chk("t4 len a", len, 32);
    chk("t4 rdy done", w_ready, 1);
    tick();
    start = 1'b0;
    chk("t4 b2b busy", w_busy, 1);
    frame_obs(0, 0, 0, len, rises, ne, bad, seq, tmo);
    chk("t4 tmo b", tmo, 0);
    chk("t4 len b", len, 32);
    chk("t4 rx", w_rx, 8'h96);
    repeat (3) tick();
    chk("t4 ndone", n_done - nd0, 2);

    // CPOL tracked live in IDLE, ignored during XFER.
    cpol = 1;
    tick();
    chk("t6 idle 1", w_sclk, 1);
    cpol = 0;
    tick();
    chk("t6 idle 0", w_sclk, 0);
    tx = 8'h5C;
    kick();
    frame_obs(0, 0, 1, len, rises, ne, bad, seq, tmo);
    chk("t6 tmo", tmo, 0);
    chk("t6 rises", rises, 8);
    chk("t6 edges", ne, 16);
    chk("t6 end", w_sclk, 0);
    chk("t6 rx", w_rx, 8'h5C);
    cpol = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
